// File: rtl/pyrite_bpi_pkg.sv
// Shared types for the Pyrite BPI flash sequencer.
// ST_POLL exists only when PYRITE_BPI_FLASH_SEQ_POLL_EN is defined.
package pyrite_bpi_pkg;

   localparam int unsigned BPI_DATA_W   = 16;
   localparam int unsigned BPI_ADDR_W   = 23;
   localparam int unsigned BPI_RGN_W    = 1;
   localparam int unsigned BPI_TIMING_W = 8;
   localparam int unsigned BPI_POLL_W   = 16;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_ADDR,
      ST_PULSE,
      ST_HOLD
`ifdef PYRITE_BPI_FLASH_SEQ_POLL_EN
      , ST_POLL
`endif
   } state_t;

   typedef struct packed {
      logic [BPI_RGN_W+BPI_ADDR_W-1:0] addr;
      logic                            wr;
      logic [BPI_DATA_W-1:0]           wdata;
      logic                            poll;
   } cmd_t;

endpackage

// File: rtl/pyrite_bpi_flash_seq.sv
// BPI NOR flash access sequencer: one word read/write per command with programmable
// setup/pulse/hold phases. Optional DQ7 write-status polling via PYRITE_BPI_FLASH_SEQ_POLL_EN.
module pyrite_bpi_flash_seq
   import pyrite_bpi_pkg::*;
#(
   parameter int unsigned DATA_W   = BPI_DATA_W,
   parameter int unsigned ADDR_W   = BPI_ADDR_W,
   parameter int unsigned RGN_W    = BPI_RGN_W,
   parameter int unsigned TIMING_W = BPI_TIMING_W,
   parameter int unsigned POLL_W   = BPI_POLL_W
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic [RGN_W+ADDR_W-1:0] cmd_addr,
   input  logic                    cmd_wr,
   input  logic [DATA_W-1:0]       cmd_wdata,
   input  logic                    cmd_poll,
   input  logic                    cmd_valid,
   output logic                    cmd_ready,
   input  logic [TIMING_W-1:0]     cfg_setup,
   input  logic [TIMING_W-1:0]     cfg_pulse,
   input  logic [TIMING_W-1:0]     cfg_hold,
   input  logic [POLL_W-1:0]       cfg_poll_max,
   output logic [DATA_W-1:0]       rsp_rdata,
   output logic                    rsp_err,
   output logic                    rsp_valid,
   output logic                    busy,
   input  logic [DATA_W-1:0]       flash_dq_i,
   output logic [DATA_W-1:0]       flash_dq_o,
   output logic                    flash_dq_oe,
   output logic [ADDR_W-1:0]       flash_addr,
   output logic [RGN_W-1:0]        flash_region,
   output logic                    flash_region_oe,
   output logic                    flash_ce_n,
   output logic                    flash_oe_n,
   output logic                    flash_we_n,
   output logic                    flash_adv_n
);

   state_t              state_q, state_d;
   cmd_t                cmd_q;
   logic [TIMING_W-1:0] cnt_q, cnt_d;
   logic [TIMING_W-1:0] setup_q, pulse_q, hold_q;
   logic [DATA_W-1:0]   rdata_q;
   logic [DATA_W-1:0]   rsp_rdata_q;
   logic                rsp_valid_q;
   logic                accept;
   logic                done;
   logic                rd_cycle;
   logic                bus_active;

`ifdef PYRITE_BPI_FLASH_SEQ_POLL_EN
   logic                polling_q;
   logic [POLL_W-1:0]   poll_cnt_q;
   logic                rsp_err_q;
   logic                timeout;

   // once polling starts, every bus cycle of this command is a status read
   assign rd_cycle = !cmd_q.wr || polling_q;
   assign rsp_err  = rsp_err_q;
`else
   logic                unused_poll;

   assign unused_poll = ^{cmd_poll, cfg_poll_max, cmd_q.poll};
   assign rd_cycle    = !cmd_q.wr;
   assign rsp_err     = 1'b0;
`endif

   assign cmd_ready = (state_q == ST_IDLE) && !rst;
   assign accept    = cmd_valid && cmd_ready;

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      done    = 1'b0;
`ifdef PYRITE_BPI_FLASH_SEQ_POLL_EN
      timeout = 1'b0;
`endif
      case (state_q)
         ST_IDLE: begin
            if (accept) begin
               state_d = ST_ADDR;
               cnt_d   = cfg_setup;
            end
         end
         ST_ADDR: begin
            if (cnt_q == '0) begin
               state_d = ST_PULSE;
               cnt_d   = pulse_q;
            end else begin
               cnt_d = cnt_q - TIMING_W'(1);
            end
         end
         ST_PULSE: begin
            if (cnt_q == '0) begin
               state_d = ST_HOLD;
               cnt_d   = hold_q;
            end else begin
               cnt_d = cnt_q - TIMING_W'(1);
            end
         end
         ST_HOLD: begin
            if (cnt_q == '0) begin
`ifdef PYRITE_BPI_FLASH_SEQ_POLL_EN
               if (cmd_q.wr && cmd_q.poll) begin
                  state_d = ST_POLL;
               end else begin
                  state_d = ST_IDLE;
                  done    = 1'b1;
               end
`else
               state_d = ST_IDLE;
               done    = 1'b1;
`endif
            end else begin
               cnt_d = cnt_q - TIMING_W'(1);
            end
         end
`ifdef PYRITE_BPI_FLASH_SEQ_POLL_EN
         // first visit follows the write itself; later visits judge the last status read
         ST_POLL: begin
            if (polling_q && (rdata_q[7] || poll_cnt_q == '0)) begin
               state_d = ST_IDLE;
               done    = 1'b1;
               timeout = !rdata_q[7];
            end else begin
               state_d = ST_ADDR;
               cnt_d   = setup_q;
            end
         end
`endif
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= ST_IDLE;
         cnt_q       <= '0;
         cmd_q       <= '0;
         setup_q     <= '0;
         pulse_q     <= '0;
         hold_q      <= '0;
         rdata_q     <= '0;
         rsp_rdata_q <= '0;
         rsp_valid_q <= 1'b0;
`ifdef PYRITE_BPI_FLASH_SEQ_POLL_EN
         polling_q   <= 1'b0;
         poll_cnt_q  <= '0;
         rsp_err_q   <= 1'b0;
`endif
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         rsp_valid_q <= done;
         if (accept) begin
            cmd_q.addr  <= cmd_addr;
            cmd_q.wr    <= cmd_wr;
            cmd_q.wdata <= cmd_wdata;
`ifdef PYRITE_BPI_FLASH_SEQ_POLL_EN
            cmd_q.poll  <= cmd_poll;
            polling_q   <= 1'b0;
            poll_cnt_q  <= cfg_poll_max;
`else
            cmd_q.poll  <= 1'b0;
`endif
            setup_q     <= cfg_setup;
            pulse_q     <= cfg_pulse;
            hold_q      <= cfg_hold;
         end
         if (state_q == ST_PULSE && cnt_q == '0 && rd_cycle)
            rdata_q <= flash_dq_i;
         // response fields only move together with rsp_valid
         if (done && rd_cycle)
            rsp_rdata_q <= rdata_q;
`ifdef PYRITE_BPI_FLASH_SEQ_POLL_EN
         if (state_q == ST_POLL) begin
            polling_q <= 1'b1;
            if (polling_q && state_d == ST_ADDR)
               poll_cnt_q <= poll_cnt_q - POLL_W'(1);
         end
         if (done)
            rsp_err_q <= timeout;
`endif
      end
   end

   assign bus_active = (state_q == ST_ADDR) || (state_q == ST_PULSE) || (state_q == ST_HOLD);

   assign busy            = (state_q != ST_IDLE);
   assign rsp_valid       = rsp_valid_q;
   assign rsp_rdata       = rsp_rdata_q;
   assign flash_addr      = cmd_q.addr[ADDR_W-1:0];
   assign flash_region    = cmd_q.addr[RGN_W+ADDR_W-1:ADDR_W];
   assign flash_region_oe = busy;
   assign flash_dq_o      = cmd_q.wdata;
   assign flash_dq_oe     = bus_active && !rd_cycle;
   assign flash_ce_n      = !bus_active;
   assign flash_adv_n     = !(state_q == ST_ADDR);
   assign flash_oe_n      = !(state_q == ST_PULSE && rd_cycle);
   assign flash_we_n      = !(state_q == ST_PULSE && !rd_cycle);

endmodule

// File: tb/tb_pyrite_bpi_flash_seq.sv
// Randomized bench for pyrite_bpi_flash_seq against a cycle-count reference model.
// Poll scenarios run when PYRITE_BPI_FLASH_SEQ_POLL_EN is defined.
module tb_pyrite_bpi_flash_seq;

   localparam int unsigned DW = 16;
   localparam int unsigned AW = 23;
   localparam int unsigned RW = 1;
   localparam int unsigned TW = 8;
   localparam int unsigned PW = 16;

   logic              clk = 1'b0;
   logic              rst;
   logic [RW+AW-1:0]  cmd_addr;
   logic              cmd_wr;
   logic [DW-1:0]     cmd_wdata;
   logic              cmd_poll;
   logic              cmd_valid;
   logic              cmd_ready;
   logic [TW-1:0]     cfg_setup, cfg_pulse, cfg_hold;
   logic [PW-1:0]     cfg_poll_max;
   logic [DW-1:0]     rsp_rdata;
   logic              rsp_err;
   logic              rsp_valid;
   logic              busy;
   logic [DW-1:0]     flash_dq_i;
   logic [DW-1:0]     flash_dq_o;
   logic              flash_dq_oe;
   logic [AW-1:0]     flash_addr;
   logic [RW-1:0]     flash_region;
   logic              flash_region_oe;
   logic              flash_ce_n, flash_oe_n, flash_we_n, flash_adv_n;

   int unsigned       n_checks = 0;
   int unsigned       n_errors = 0;
   logic [DW-1:0]     data_seq [0:1023];
   logic [DW-1:0]     last_rdata;

   always #5 clk = ~clk;

   pyrite_bpi_flash_seq #(
      .DATA_W(DW), .ADDR_W(AW), .RGN_W(RW), .TIMING_W(TW), .POLL_W(PW)
   ) dut (
      .clk(clk), .rst(rst),
      .cmd_addr(cmd_addr), .cmd_wr(cmd_wr), .cmd_wdata(cmd_wdata), .cmd_poll(cmd_poll),
      .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
      .cfg_setup(cfg_setup), .cfg_pulse(cfg_pulse), .cfg_hold(cfg_hold),
      .cfg_poll_max(cfg_poll_max),
      .rsp_rdata(rsp_rdata), .rsp_err(rsp_err), .rsp_valid(rsp_valid), .busy(busy),
      .flash_dq_i(flash_dq_i), .flash_dq_o(flash_dq_o), .flash_dq_oe(flash_dq_oe),
      .flash_addr(flash_addr), .flash_region(flash_region), .flash_region_oe(flash_region_oe),
      .flash_ce_n(flash_ce_n), .flash_oe_n(flash_oe_n), .flash_we_n(flash_we_n),
      .flash_adv_n(flash_adv_n)
   );

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   // one idle cycle between commands; the previous completion strobe must be gone
   task automatic idle_gap();
      @(negedge clk);
      check("rsp_pulse_width", 32'(rsp_valid), 32'd0);
   endtask

   // Issue one non-polled command starting at a negedge; returns at the negedge of the rsp_valid cycle.
   task automatic run_op(input logic [RW+AW-1:0] addr, input logic wr, input logic [DW-1:0] wd,
                         input logic poll, input int unsigned s, input int unsigned p,
                         input int unsigned h, input bit frc, input logic [DW-1:0] frc_val);
      int unsigned lat = s + p + h + 3;
      int unsigned ce_lo = 0, adv_lo = 0, oe_lo = 0, we_lo = 0, dqoe_hi = 0, clash = 0;
      int unsigned first_strobe = 999;
      int unsigned k;
      bit          got_rsp = 0;
      logic [DW-1:0] exp_rd;
      for (int unsigned i = 0; i <= lat; i++) begin
         data_seq[i] = DW'($urandom);
         if (frc && i >= s + 1 && i <= s + p + 1) data_seq[i] = frc_val;
      end
      cmd_addr     = addr;
      cmd_wr       = wr;
      cmd_wdata    = wd;
      cmd_poll     = poll;
      cfg_setup    = TW'(s);
      cfg_pulse    = TW'(p);
      cfg_hold     = TW'(h);
      cfg_poll_max = PW'($urandom);
      cmd_valid    = 1'b1;
      check("ready_idle", 32'(cmd_ready), 32'd1);
      @(posedge clk);
      #1;
      cmd_valid = 1'b0;
      cfg_setup = TW'(s) ^ 8'h05;
      cfg_pulse = TW'(p) ^ 8'h03;
      cfg_hold  = TW'(h) ^ 8'h06;
      for (k = 0; k < lat + 50; k++) begin
         if (k > 0) begin
            @(posedge clk);
            #1;
         end
         flash_dq_i = (k <= lat) ? data_seq[k] : DW'($urandom);
         @(negedge clk);
         if (k == 0) begin
            check("ce_fall", 32'(flash_ce_n), 32'd0);
            check("adv_first", 32'(flash_adv_n), 32'd0);
            check("addr", 32'(flash_addr), 32'(addr[AW-1:0]));
            check("region", 32'(flash_region), 32'(addr[RW+AW-1:AW]));
            check("region_oe", 32'(flash_region_oe), 32'd1);
            if (wr) check("dq_o", 32'(flash_dq_o), 32'(wd));
         end
         if (rsp_valid) begin
            got_rsp = 1;
            break;
         end
         ce_lo   += 32'(!flash_ce_n);
         adv_lo  += 32'(!flash_adv_n);
         oe_lo   += 32'(!flash_oe_n);
         we_lo   += 32'(!flash_we_n);
         dqoe_hi += 32'(flash_dq_oe);
         clash   += 32'(flash_dq_oe && !flash_oe_n);
         if ((!flash_oe_n || !flash_we_n) && first_strobe == 999) first_strobe = k;
      end
      exp_rd = wr ? last_rdata : data_seq[s + p + 1];
      last_rdata = exp_rd;
      check("rsp_seen", 32'(got_rsp), 32'd1);
      check("latency", k, lat);
      check("ce_low_cycles", ce_lo, lat);
      check("adv_low_cycles", adv_lo, s + 1);
      check("oe_low_cycles", oe_lo, wr ? 0 : p + 1);
      check("we_low_cycles", we_lo, wr ? p + 1 : 0);
      check("dq_oe_cycles", dqoe_hi, wr ? lat : 0);
      check("dq_oe_vs_oe", clash, 0);
      check("strobe_start", first_strobe, s + 1);
      check("ce_high_at_rsp", 32'(flash_ce_n), 32'd1);
      check("ready_at_rsp", 32'(cmd_ready), 32'd1);
      check("rsp_rdata", 32'(rsp_rdata), 32'(exp_rd));
      check("rsp_err", 32'(rsp_err), 32'd0);
   endtask

   task automatic check_reset_outputs(input string tag);
      check({tag, "_strobes"}, 32'({flash_ce_n, flash_oe_n, flash_we_n, flash_adv_n}), 32'hF);
      check({tag, "_dq_oe"}, 32'(flash_dq_oe), 32'd0);
      check({tag, "_region_oe"}, 32'(flash_region_oe), 32'd0);
      check({tag, "_busy"}, 32'(busy), 32'd0);
      check({tag, "_rsp_valid"}, 32'(rsp_valid), 32'd0);
      check({tag, "_rsp_rdata"}, 32'(rsp_rdata), 32'd0);
      check({tag, "_rsp_err"}, 32'(rsp_err), 32'd0);
      check({tag, "_addr"}, 32'({flash_region, flash_addr}), 32'd0);
      check({tag, "_dq_o"}, 32'(flash_dq_o), 32'd0);
   endtask

   // Reset lands in the middle of a read PULSE; the command must vanish without a response.
   task automatic run_reset();
      int unsigned strays = 0;
      cmd_addr  = (RW + AW)'($urandom);
      cmd_wr    = 1'b0;
      cmd_wdata = DW'($urandom);
      cmd_poll  = 1'b0;
      cfg_setup = 8'd1;
      cfg_pulse = 8'd5;
      cfg_hold  = 8'd1;
      cmd_valid = 1'b1;
      @(posedge clk);
      #1;
      cmd_valid = 1'b0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      check("rst_pre_in_pulse", 32'(flash_oe_n), 32'd0);
      rst = 1'b1;
      #1;
      check("rst_ready_low", 32'(cmd_ready), 32'd0);
      @(posedge clk);
      #1;
      rst = 1'b0;
      @(negedge clk);
      check_reset_outputs("midop_rst");
      repeat (20) begin
         @(negedge clk);
         strays += 32'(rsp_valid);
      end
      check("midop_rst_no_rsp", strays, 0);
      last_rdata = '0;
   endtask

`ifdef PYRITE_BPI_FLASH_SEQ_POLL_EN
   // Flash status model: read number n (1-based) returns DQ7 = (n > nz), low bits = n.
   task automatic run_poll(input int unsigned nz, input int unsigned pmax);
      int unsigned reads = 0, clash = 0, exp_reads;
      bit          exp_err, got_rsp = 0;
      logic        prev_oe_n = 1'b1;
      logic [DW-1:0] exp_rd;
      exp_err   = (nz > pmax);
      exp_reads = exp_err ? pmax + 1 : nz + 1;
      cmd_addr     = (RW + AW)'($urandom);
      cmd_wr       = 1'b1;
      cmd_wdata    = DW'($urandom);
      cmd_poll     = 1'b1;
      cfg_setup    = TW'($urandom_range(0, 2));
      cfg_pulse    = TW'($urandom_range(0, 2));
      cfg_hold     = TW'($urandom_range(0, 2));
      cfg_poll_max = PW'(pmax);
      cmd_valid    = 1'b1;
      check("poll_ready", 32'(cmd_ready), 32'd1);
      @(posedge clk);
      #1;
      cmd_valid = 1'b0;
      for (int unsigned k = 0; k < 3000; k++) begin
         if (k > 0) begin
            @(posedge clk);
            #1;
         end
         if (!flash_oe_n && prev_oe_n) reads++;
         prev_oe_n  = flash_oe_n;
         flash_dq_i = {8'h00, (reads > nz), 7'(reads)};
         @(negedge clk);
         clash += 32'(flash_dq_oe && !flash_oe_n);
         if (rsp_valid) begin
            got_rsp = 1;
            break;
         end
      end
      exp_rd = {8'h00, !exp_err, 7'(exp_reads)};
      last_rdata = exp_rd;
      check("poll_rsp_seen", 32'(got_rsp), 32'd1);
      check("poll_reads", reads, exp_reads);
      check("poll_err", 32'(rsp_err), 32'(exp_err));
      check("poll_rdata", 32'(rsp_rdata), 32'(exp_rd));
      check("poll_dq_oe_vs_oe", clash, 0);
   endtask
`endif

   initial begin
      rst          = 1'b1;
      cmd_addr     = '0;
      cmd_wr       = 1'b0;
      cmd_wdata    = '0;
      cmd_poll     = 1'b0;
      cmd_valid    = 1'b0;
      cfg_setup    = '0;
      cfg_pulse    = '0;
      cfg_hold     = '0;
      cfg_poll_max = '0;
      flash_dq_i   = '0;
      last_rdata   = '0;

      repeat (3) @(posedge clk);
      @(negedge clk);
      check("rst_ready", 32'(cmd_ready), 32'd0);
      check_reset_outputs("por");
      @(posedge clk);
      #1;
      rst = 1'b0;
      @(negedge clk);

      // read 2/3/1 with A5A5 presented through PULSE
      run_op((RW + AW)'($urandom), 1'b0, '0, 1'b0, 2, 3, 1, 1'b1, 16'hA5A5);
      idle_gap();
      // write 0040 to region 1, word 12345, all-zero timing
      run_op({1'b1, 23'h12345}, 1'b1, 16'h0040, 1'b0, 0, 0, 0, 1'b0, '0);
      idle_gap();
      // back-to-back reads, the second taken in the first one's rsp_valid cycle
      run_op((RW + AW)'($urandom), 1'b0, '0, 1'b0, 1, 1, 0, 1'b0, '0);
      run_op((RW + AW)'($urandom), 1'b0, '0, 1'b0, 0, 2, 1, 1'b0, '0);
      idle_gap();
      // setup of 0 must survive cfg_setup moving to 5 mid-operation
      run_op((RW + AW)'($urandom), 1'b0, '0, 1'b0, 0, 1, 0, 1'b0, '0);
      idle_gap();
      run_reset();

      for (int unsigned n = 0; n < 40; n++) begin
         logic pl;
`ifdef PYRITE_BPI_FLASH_SEQ_POLL_EN
         pl = 1'b0;
`else
         pl = 1'($urandom);
`endif
         if ($urandom_range(0, 1) == 0) idle_gap();
         run_op((RW + AW)'($urandom), 1'($urandom), DW'($urandom), pl,
                $urandom_range(0, 7), $urandom_range(0, 7), $urandom_range(0, 7),
                1'b0, '0);
      end

`ifdef PYRITE_BPI_FLASH_SEQ_POLL_EN
      idle_gap();
      run_poll(3, 10);
      idle_gap();
      run_poll(1000, 1);
      for (int unsigned n = 0; n < 6; n++) begin
         idle_gap();
         run_poll($urandom_range(0, 6), $urandom_range(0, 4));
      end
`endif

      idle_gap();
      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
